// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register controller.
//   t_spi_ctrl_state : controller frame state
//   K_CMD_*_BIT      : command field positions, counted down from the word MSB
//   K_*_WORD_DEF     : default transmit words for frame sync and read timeout
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_DATA = 3'd5
    } t_spi_ctrl_state;

    // Offsets below the MSB so the fields stay put for any data width.
    localparam int unsigned K_CMD_RW_BIT   = 0;
    localparam int unsigned K_CMD_AINC_BIT = 1;

    localparam logic [15:0] K_SYNC_WORD_DEF = 16'h5A5A;
    localparam logic [15:0] K_ERR_WORD_DEF  = 16'hDEAD;

endpackage

// File: rtl/spi_rd_timeout.sv
// Loadable down-counter bounding how long a register read may take.
//   i_clk, i_rst  : clock, synchronous active-high reset (clears count)
//   i_load        : load K_LOAD_VAL
//   i_en          : count down by one, saturating at zero
//   o_expired_c   : count is zero (combinational from the count register)
module spi_rd_timeout #(
    parameter int unsigned K_LOAD_VAL = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned K_CW = (K_LOAD_VAL < 1) ? 1 : $clog2(K_LOAD_VAL + 1);

    logic [K_CW-1:0] count_q;

    // Count register: load has priority over decrement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= K_CW'(K_LOAD_VAL);
        end else if (i_en && (count_q != '0)) begin
            count_q <= count_q - K_CW'(1);
        end
    end

    assign o_expired_c = (count_q == '0);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller between spi_slave's word interface and a register bus.
// The first word of a chip-select frame is a command (rw, auto-increment,
// address); later words are write data or dummies that clock out read data
// fetched one word ahead. K_AWIDTH must not exceed K_DWIDTH-2.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_selected, i_rx_data,
//   i_rx_event, i_txe         : spi_slave status and receive side
//   o_tx_data, o_tx_valid     : spi_slave transmit load (single-cycle pulse)
//   o_reg_addr, o_reg_wdata,
//   o_reg_we, o_reg_re        : register bus request
//   i_reg_rdata, i_reg_rvalid : register bus read completion
//   o_err                     : read timeout or frame cut during a read
//   o_busy                    : controller not idle
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned         K_DWIDTH     = 16,
    parameter int unsigned         K_AWIDTH     = 8,
    parameter int unsigned         K_RD_TIMEOUT = 15,
    parameter logic [K_DWIDTH-1:0] K_SYNC_WORD  = K_DWIDTH'(K_SYNC_WORD_DEF),
    parameter logic [K_DWIDTH-1:0] K_ERR_WORD   = K_DWIDTH'(K_ERR_WORD_DEF)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_selected,
    input  logic [K_DWIDTH-1:0] i_rx_data,
    input  logic                i_rx_event,
    input  logic                i_txe,
    output logic [K_DWIDTH-1:0] o_tx_data,
    output logic                o_tx_valid,
    output logic [K_AWIDTH-1:0] o_reg_addr,
    output logic [K_DWIDTH-1:0] o_reg_wdata,
    output logic                o_reg_we,
    output logic                o_reg_re,
    input  logic [K_DWIDTH-1:0] i_reg_rdata,
    input  logic                i_reg_rvalid,
    output logic                o_err,
    output logic                o_busy
);

    localparam int unsigned K_RW_POS   = K_DWIDTH - 1 - K_CMD_RW_BIT;
    localparam int unsigned K_AINC_POS = K_DWIDTH - 1 - K_CMD_AINC_BIT;

    t_spi_ctrl_state       state_q, state_d;
    logic                  sel_q;
    logic [K_AWIDTH-1:0]   addr_q, addr_d;
    logic                  ainc_q, ainc_d;

    logic [K_DWIDTH-1:0]   tx_data_d;
    logic                  tx_valid_d;
    logic [K_AWIDTH-1:0]   reg_addr_d;
    logic [K_DWIDTH-1:0]   reg_wdata_d;
    logic                  reg_we_d;
    logic                  reg_re_d;
    logic                  err_d;

    logic                  tmr_load_c;
    logic                  tmr_en_c;
    logic                  tmr_expired_c;

    // Transmit-buffer status is not needed for sequencing.
    logic                  unused_txe;
    assign unused_txe = i_txe;

    spi_rd_timeout #(
        .K_LOAD_VAL (K_RD_TIMEOUT)
    ) u_rd_timeout (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (tmr_load_c),
        .i_en        (tmr_en_c),
        .o_expired_c (tmr_expired_c)
    );

    // State, context and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            ainc_q      <= 1'b0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= i_selected;
            addr_q      <= addr_d;
            ainc_q      <= ainc_d;
            o_tx_data   <= tx_data_d;
            o_tx_valid  <= tx_valid_d;
            o_reg_addr  <= reg_addr_d;
            o_reg_wdata <= reg_wdata_d;
            o_reg_we    <= reg_we_d;
            o_reg_re    <= reg_re_d;
            o_err       <= err_d;
            o_busy      <= (state_d != ST_IDLE);
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ainc_d      = ainc_q;
        tx_data_d   = o_tx_data;
        tx_valid_d  = 1'b0;
        reg_addr_d  = o_reg_addr;
        reg_wdata_d = o_reg_wdata;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        err_d       = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_en_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Preload the sync word so it shifts out under the command.
                if (i_selected && !sel_q) begin
                    state_d    = ST_CMD;
                    tx_valid_d = 1'b1;
                    tx_data_d  = K_SYNC_WORD;
                end
            end

            ST_CMD: begin
                if (!i_selected) begin
                    state_d = ST_IDLE;
                end else if (i_rx_event) begin
                    addr_d  = i_rx_data[K_AWIDTH-1:0];
                    ainc_d  = i_rx_data[K_AINC_POS];
                    state_d = i_rx_data[K_RW_POS] ? ST_RD_REQ : ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                // A word completing in the deselect cycle is still written.
                if (i_rx_event) begin
                    reg_we_d    = 1'b1;
                    reg_wdata_d = i_rx_data;
                    reg_addr_d  = addr_q;
                    if (ainc_q) begin
                        addr_d = addr_q + K_AWIDTH'(1);
                    end
                end
                if (!i_selected) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_REQ: begin
                if (!i_selected) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    reg_re_d   = 1'b1;
                    reg_addr_d = addr_q;
                    tmr_load_c = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (!i_selected) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (i_reg_rvalid) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = i_reg_rdata;
                    state_d    = ST_RD_DATA;
                end else if (tmr_expired_c) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = K_ERR_WORD;
                    err_d      = 1'b1;
                    state_d    = ST_RD_DATA;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            ST_RD_DATA: begin
                // Fetched word has been clocked out; fetch the next one.
                if (!i_selected) begin
                    state_d = ST_IDLE;
                end else if (i_rx_event) begin
                    if (ainc_q) begin
                        addr_d = addr_q + K_AWIDTH'(1);
                    end
                    state_d = ST_RD_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed vector table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_spi_reg_ctrl;

    localparam int GAP     = 24;
    localparam int TIMEOUT = 15;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_selected;
    logic [15:0] i_rx_data;
    logic        i_rx_event;
    logic        i_txe;
    logic [15:0] o_tx_data;
    logic        o_tx_valid;
    logic [7:0]  o_reg_addr;
    logic [15:0] o_reg_wdata;
    logic        o_reg_we;
    logic        o_reg_re;
    logic [15:0] i_reg_rdata;
    logic        i_reg_rvalid;
    logic        o_err;
    logic        o_busy;

    spi_reg_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_selected   (i_selected),
        .i_rx_data    (i_rx_data),
        .i_rx_event   (i_rx_event),
        .i_txe        (i_txe),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_reg_addr   (o_reg_addr),
        .o_reg_wdata  (o_reg_wdata),
        .o_reg_we     (o_reg_we),
        .o_reg_re     (o_reg_re),
        .i_reg_rdata  (i_reg_rdata),
        .i_reg_rvalid (i_reg_rvalid),
        .o_err        (o_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] bus_mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] fdat [3];
    int          rd_lat;

    logic [15:0] mon_tx[$];
    logic [23:0] mon_wr[$];
    logic [7:0]  mon_rd[$];
    int          mon_err;
    int          mon_badtx;

    logic [15:0] exp_tx[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          exp_err;

    typedef struct packed {
        logic [15:0]      cmd;
        int               n;
        logic [2:0][15:0] d;
        int               lat;
        int               ntx;
        logic [2:0][15:0] tx;
        int               nwr;
        logic [2:0][23:0] wr;
        int               nrd;
        logic [2:0][7:0]  rd;
        int               err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [15:0] cmd, input int n,
                                input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                                input int lat, input int ntx,
                                input logic [15:0] t1, input logic [15:0] t2, input logic [15:0] t3,
                                input int nwr, input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                                input int nrd, input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                input int err);
        vec_t v;
        v.cmd = cmd; v.n = n; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.lat = lat;
        v.ntx = ntx; v.tx[0] = t1; v.tx[1] = t2; v.tx[2] = t3;
        v.nwr = nwr; v.wr[0] = w0; v.wr[1] = w1; v.wr[2] = w2;
        v.nrd = nrd; v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2;
        v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({o_tx_data, o_tx_valid, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_err, o_busy});
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_tx.delete(); mon_wr.delete(); mon_rd.delete();
        mon_err = 0; mon_badtx = 0;
    endtask

    // Register bus responder and output monitor, sampled away from the active edge.
    int          rsp_cnt;
    bit          rsp_pend;
    logic [7:0]  rsp_addr;
    initial begin
        i_reg_rvalid = 1'b0;
        i_reg_rdata  = 16'h0;
        rsp_pend     = 1'b0;
        rsp_cnt      = 0;
        rsp_addr     = 8'h0;
        forever begin
            @(negedge i_clk);
            i_reg_rvalid = 1'b0;
            if (o_tx_valid) begin
                mon_tx.push_back(o_tx_data);
                if (!i_selected) mon_badtx++;
            end
            if (o_reg_we) begin
                mon_wr.push_back({o_reg_addr, o_reg_wdata});
                bus_mem[o_reg_addr] = o_reg_wdata;
            end
            if (o_err) mon_err++;
            if (o_reg_re) begin
                mon_rd.push_back(o_reg_addr);
                rsp_pend = (rd_lat != 0);
                rsp_cnt  = rd_lat;
                rsp_addr = o_reg_addr;
            end else if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    i_reg_rvalid = 1'b1;
                    i_reg_rdata  = bus_mem[rsp_addr];
                    rsp_pend     = 1'b0;
                end
            end
        end
    end

    // Frame-level reference: what a whole frame should produce on each interface.
    task automatic model_frame(input logic [15:0] cmd, input int n, input int lat);
        logic [7:0] a;
        a = cmd[7:0];
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        exp_tx.push_back(16'h5A5A);
        exp_err = 0;
        if (!cmd[15]) begin
            for (int i = 0; i < n; i++) begin
                exp_wr.push_back({a, fdat[i]});
                ref_mem[a] = fdat[i];
                if (cmd[14]) a = a + 8'd1;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_rd.push_back(a);
                if (lat >= 1 && lat <= TIMEOUT) begin
                    exp_tx.push_back(ref_mem[a]);
                end else begin
                    exp_tx.push_back(16'hDEAD);
                    exp_err++;
                end
                if (cmd[14]) a = a + 8'd1;
            end
            exp_err++;  // the prefetch after the last word is cut by deselect
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        repeat (GAP) tick();
        i_rx_data  = w;
        i_rx_event = 1'b1;
        tick();
        i_rx_event = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] cmd, input int n);
        clear_mon();
        i_selected = 1'b1;
        send_word(cmd);
        for (int i = 0; i < n; i++) send_word(fdat[i]);
        i_selected = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, " tx count"}, 64'(mon_tx.size()), 64'(exp_tx.size()));
        for (int k = 0; k < exp_tx.size() && k < mon_tx.size(); k++)
            check($sformatf("%s tx[%0d]", tag, k), 64'(mon_tx[k]), 64'(exp_tx[k]));
        check({tag, " write count"}, 64'(mon_wr.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < mon_wr.size(); k++)
            check($sformatf("%s write[%0d]", tag, k), 64'(mon_wr[k]), 64'(exp_wr[k]));
        check({tag, " read count"}, 64'(mon_rd.size()), 64'(exp_rd.size()));
        for (int k = 0; k < exp_rd.size() && k < mon_rd.size(); k++)
            check($sformatf("%s read addr[%0d]", tag, k), 64'(mon_rd[k]), 64'(exp_rd[k]));
        check({tag, " err pulses"}, 64'(mon_err), 64'(exp_err));
        check({tag, " tx while deselected"}, 64'(mon_badtx), 64'd0);
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        rd_lat = v.lat;
        for (int k = 0; k < 3; k++) fdat[k] = v.d[k];
        model_frame(v.cmd, v.n, v.lat);  // keeps ref_mem in step with the bus
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        exp_tx.push_back(16'h5A5A);
        for (int k = 0; k < v.ntx - 1; k++) exp_tx.push_back(v.tx[k]);
        for (int k = 0; k < v.nwr; k++) exp_wr.push_back(v.wr[k]);
        for (int k = 0; k < v.nrd; k++) exp_rd.push_back(v.rd[k]);
        exp_err = v.err;
        run_frame(v.cmd, v.n);
        cmp_frame($sformatf("vec%0d", i));
    endtask

    initial begin
        i_rst = 1'b1; i_selected = 1'b0; i_rx_data = 16'h0; i_rx_event = 1'b0;
        i_txe = 1'b1; rd_lat = 3;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 16'hA000 | 16'(i);
            ref_mem[i] = 16'hA000 | 16'(i);
        end
        bus_mem[8'h20] = 16'hBEEF;
        ref_mem[8'h20] = 16'hBEEF;

        //            cmd      n  d0        d1        d2  lat ntx t1        t2        t3        nwr w0                 w1                 w2 nrd r0     r1     r2 err
        vecs[0]  = mk(16'h4010, 2, 16'h1111, 16'h2222, 0, 3,  1,  0,        0,        0,        2,  {8'h10, 16'h1111}, {8'h11, 16'h2222}, 0, 0, 0,     0,     0, 0);
        vecs[1]  = mk(16'h8020, 2, 0,        0,        0, 3,  3,  16'hBEEF, 16'hBEEF, 0,        0,  0,                 0,                 0, 2, 8'h20, 8'h20, 0, 1);
        vecs[2]  = mk(16'hC0FF, 3, 0,        0,        0, 5,  4,  16'hA0FF, 16'hA000, 16'hA001, 0,  0,                 0,                 0, 3, 8'hFF, 8'h00, 8'h01, 1);
        vecs[3]  = mk(16'h8030, 1, 0,        0,        0, 0,  2,  16'hDEAD, 0,        0,        0,  0,                 0,                 0, 1, 8'h30, 0,     0, 2);
        vecs[4]  = mk(16'h8040, 1, 0,        0,        0, 15, 2,  16'hA040, 0,        0,        0,  0,                 0,                 0, 1, 8'h40, 0,     0, 1);
        vecs[5]  = mk(16'h8041, 1, 0,        0,        0, 16, 2,  16'hDEAD, 0,        0,        0,  0,                 0,                 0, 1, 8'h41, 0,     0, 2);
        vecs[6]  = mk(16'h0005, 2, 16'h1234, 16'h5678, 0, 3,  1,  0,        0,        0,        2,  {8'h05, 16'h1234}, {8'h05, 16'h5678}, 0, 0, 0,     0,     0, 0);
        vecs[7]  = mk(16'h8005, 1, 0,        0,        0, 1,  2,  16'h5678, 0,        0,        0,  0,                 0,                 0, 1, 8'h05, 0,     0, 1);
        vecs[8]  = mk(16'h3F0A, 1, 16'h0A0A, 0,        0, 3,  1,  0,        0,        0,        1,  {8'h0A, 16'h0A0A}, 0,                 0, 0, 0,     0,     0, 0);
        vecs[9]  = mk(16'h40FF, 2, 16'h7777, 16'h8888, 0, 3,  1,  0,        0,        0,        2,  {8'hFF, 16'h7777}, {8'h00, 16'h8888}, 0, 0, 0,     0,     0, 0);
        vecs[10] = mk(16'hC0FF, 2, 0,        0,        0, 2,  3,  16'h7777, 16'h8888, 0,        0,  0,                 0,                 0, 2, 8'hFF, 8'h00, 0, 1);
        vecs[11] = mk(16'hBF20, 1, 0,        0,        0, 7,  2,  16'hBEEF, 0,        0,        0,  0,                 0,                 0, 1, 8'h20, 0,     0, 1);

        repeat (3) tick();
        check("outputs in reset", outs(), 64'd0);
        i_rst = 1'b0;
        tick();
        check("idle after reset", outs(), 64'd0);

        for (int i = 0; i < NV; i++) apply_vec(i);

        // Deselect while waiting for read data.
        clear_mon();
        rd_lat = 0;
        i_selected = 1'b1;
        send_word(16'h8050);
        repeat (3) tick();
        i_selected = 1'b0;
        tick();
        check("rd_wait deselect busy", 64'(o_busy), 64'd0);
        check("rd_wait deselect err", 64'(o_err), 64'd1);
        check("rd_wait deselect tx_valid", 64'(o_tx_valid), 64'd0);
        repeat (4) tick();
        check("rd_wait deselect reads", 64'(mon_rd.size()), 64'd1);
        check("rd_wait deselect tx loads", 64'(mon_tx.size()), 64'd1);
        check("rd_wait deselect err pulses", 64'(mon_err), 64'd1);
        apply_vec(0);

        // Data word completing in the same cycle as deselect is still written.
        clear_mon();
        i_selected = 1'b1;
        send_word(16'h0060);
        repeat (GAP) tick();
        i_rx_data = 16'hCAFE; i_rx_event = 1'b1; i_selected = 1'b0;
        tick();
        i_rx_event = 1'b0;
        check("write on deselect", 64'({o_reg_we, o_reg_addr, o_reg_wdata, o_busy}),
              64'({1'b1, 8'h60, 16'hCAFE, 1'b0}));
        ref_mem[8'h60] = 16'hCAFE;
        repeat (4) tick();
        check("write on deselect count", 64'(mon_wr.size()), 64'd1);

        // Reset while a write word arrives in WR_DATA.
        clear_mon();
        i_selected = 1'b1;
        send_word(16'h4010);
        repeat (GAP) tick();
        i_rx_data = 16'h9999; i_rx_event = 1'b1; i_rst = 1'b1; i_selected = 1'b0;
        tick();
        i_rx_event = 1'b0; i_rst = 1'b0;
        check("reset in wr_data outputs", outs(), 64'd0);
        repeat (4) tick();
        check("reset in wr_data writes", 64'(mon_wr.size()), 64'd0);
        apply_vec(0);

        // Randomized frames against the reference model.
        for (int it = 0; it < 30; it++) begin
            logic [15:0] cmd;
            int          n;
            int          r;
            cmd = 16'($urandom);
            n   = $urandom_range(0, 3);
            for (int k = 0; k < 3; k++) fdat[k] = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      rd_lat = 0;
            else if (r == 1) rd_lat = $urandom_range(16, 20);
            else             rd_lat = $urandom_range(1, 15);
            model_frame(cmd, n, rd_lat);
            run_frame(cmd, n);
            cmp_frame($sformatf("rand%0d cmd=%h n=%0d lat=%0d", it, cmd, n, rd_lat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
